baud_tick_gen: RTL and testbench

//  Parametrised UART timing generator, successor to the fixed-count baud divider.
//  A fractional phase accumulator gives an oversampling strobe at OVERSAMPLE x baud with no cumulative rounding drift.
//  A sub-counter derives a per-bit strobe and a mid-bit strobe from it.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/baud_tick_if.sv | 30 +++
 rtl/baud_phase_acc.sv | 36 +++
 rtl/baud_tick_gen.sv | 97 +++++++++
 tb/tb_baud_tick_gen.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: baud table, phase increment math, defaults.
// Used by the baud generator and the TX/RX state machines.
package uart_pkg;

  localparam int CLK_HZ_DEF     = 50_000_000;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int ACC_W_DEF      = 24;
  localparam int SEL_W_DEF      = 3;

  function automatic int baud_rate(input int idx);
    case (idx)
      0:       return 300;
      1:       return 1200;
      2:       return 4800;
      3:       return 9600;
      4:       return 19200;
      5:       return 38400;
      6:       return 57600;
      default: return 115200;
    endcase
  endfunction

  // round(baud * os * 2**acc_w / clk_hz), 64-bit intermediates
  function automatic logic [63:0] baud_inc(
    input int baud,
    input int os,
    input int acc_w,
    input int clk_hz
  );
    logic [63:0] num;
    logic [63:0] den;
    num = (64'(baud) * 64'(os)) << acc_w;
    den = 64'(clk_hz);
    return (num + (den >> 1)) / den;
  endfunction

endpackage

// File: rtl/baud_tick_if.sv
// Control inputs and strobe outputs of the shared baud generator.
// master = UART top level, slave = baud_tick_gen.
interface baud_tick_if
  import uart_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int SUB_W = $clog2(OVERSAMPLE_DEF)
);

  logic             enable;
  logic [SEL_W-1:0] baud_select;
  logic             resync;
  logic             sample_ENABLE;
  logic             bit_ENABLE;
  logic             mid_ENABLE;
  logic [SUB_W-1:0] sub_cnt;

  modport master (
    output enable, baud_select, resync,
    input  sample_ENABLE, bit_ENABLE,
    input  mid_ENABLE, sub_cnt
  );

  modport slave (
    input  enable, baud_select, resync,
    output sample_ENABLE, bit_ENABLE,
    output mid_ENABLE, sub_cnt
  );

endinterface

// File: rtl/baud_phase_acc.sv
// Fractional phase accumulator; carry out marks one sample period.
// carry_nx is the overflow of this cycle, carry is it registered.
module baud_phase_acc
  import uart_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [ACC_W-1:0] inc,
  output logic             carry_nx,
  output logic             carry
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic             run;

  assign run      = enable & ~clear;
  assign sum      = {1'b0, acc} + {1'b0, inc};
  assign carry_nx = run & sum[ACC_W];

  // advance phase modulo 2**ACC_W, or hold at zero when stopped/cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      carry <= 1'b0;
    end else begin
      carry <= carry_nx;
      acc   <= run ? sum[ACC_W-1:0] : '0;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// UART timing generator: sample, bit and mid-bit strobes from a
// fractional phase accumulator, with select-change restart and resync.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int SEL_W      = SEL_W_DEF
) (
  input logic        clk,
  input logic        reset,
  baud_tick_if.slave bus
);

  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam int NSEL  = 1 << SEL_W;

  localparam logic [SUB_W-1:0] SUB_LAST =
    SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_PREMID =
    SUB_W'(OVERSAMPLE / 2 - 1);

  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4 ||
      OVERSAMPLE > 64) begin : g_bad_os
    $error("baud_tick_gen: OVERSAMPLE must be even, 4..64");
  end

  logic [ACC_W-1:0] inc_tab [NSEL];

  for (genvar i = 0; i < NSEL; i++) begin : g_inc
    localparam logic [63:0] INC =
      baud_inc(baud_rate(i), OVERSAMPLE, ACC_W, CLK_HZ);
    if (INC >= (64'd1 << (ACC_W - 1))) begin : g_bad_inc
      $error("baud_tick_gen: strobe rate not below clk/2");
    end
    assign inc_tab[i] = INC[ACC_W-1:0];
  end

  logic [SEL_W-1:0] sel_q;
  logic             clr;
  logic             sub_clr;
  logic             carry_nx;
  logic             carry_q;
  logic [ACC_W-1:0] inc_sel;
  logic [SUB_W-1:0] sub_q;
  logic             wrap;
  logic             bit_q;
  logic             mid_q;

  assign inc_sel = inc_tab[bus.baud_select];
  assign clr     = bus.resync | (bus.baud_select != sel_q);
  assign sub_clr = ~bus.enable | clr;
  assign wrap    = (sub_q == SUB_LAST);

  baud_phase_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .clear    (clr),
    .inc      (inc_sel),
    .carry_nx (carry_nx),
    .carry    (carry_q)
  );

  // previous select; a mismatch restarts timing at the new rate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sel_q <= '0;
    else        sel_q <= bus.baud_select;
  end

  // sample index and bit / mid-bit strobes, aligned with the carry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_q <= '0;
      bit_q <= 1'b0;
      mid_q <= 1'b0;
    end else begin
      bit_q <= carry_nx & wrap;
      mid_q <= carry_nx & (sub_q == SUB_PREMID);
      unique case (1'b1)
        sub_clr:          sub_q <= '0;
        carry_nx & wrap:  sub_q <= '0;
        carry_nx & ~wrap: sub_q <= sub_q + 1'b1;
        default:          sub_q <= sub_q;
      endcase
    end
  end

  assign bus.sample_ENABLE = carry_q;
  assign bus.bit_ENABLE    = bit_q;
  assign bus.mid_ENABLE    = mid_q;
  assign bus.sub_cnt       = sub_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: phase-crossing model checked every cycle,
// plus directed timing scenarios with hand-computed expectations.
module tb_baud_tick_gen;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  baud_tick_if bus ();

  baud_tick_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  localparam longint TWO24 = 64'd1 << 24;

  int     baud_tab [8] = '{300, 1200, 4800, 9600,
                           19200, 38400, 57600, 115200};
  longint m_inc [8];

  // model state: cycles and strobes since the last clear
  longint m_n   = 0;
  longint m_k   = 0;
  int     m_sel = 0;
  bit     e_s   = 0;
  bit     e_b   = 0;
  bit     e_m   = 0;
  int     e_sub = 0;

  task automatic check(input string name,
                       input longint act,
                       input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name,
                             input longint act,
                             input longint lo,
                             input longint hi);
    n_assert++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d",
               name, act, lo, hi);
    end
  endtask

  // model: a strobe is due on each cycle where n*inc crosses a
  // multiple of 2**24, counting n from the last clear
  initial begin
    longint inc;
    for (int i = 0; i < 8; i++)
      m_inc[i] = (longint'(baud_tab[i]) * 16 * TWO24 + 25_000_000)
                 / 50_000_000;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_n = 0; m_k = 0; m_sel = 0;
        e_s = 0; e_b = 0; e_m = 0; e_sub = 0;
      end else begin
        if (!bus.enable || bus.resync ||
            int'(bus.baud_select) != m_sel) begin
          m_n = 0; m_k = 0;
          e_s = 0; e_b = 0; e_m = 0; e_sub = 0;
        end else begin
          m_n++;
          inc = m_inc[bus.baud_select];
          if ((m_n * inc) / TWO24 != ((m_n - 1) * inc) / TWO24) begin
            m_k++;
            e_s   = 1;
            e_sub = int'(m_k % 16);
            e_b   = (e_sub == 0);
            e_m   = (e_sub == 8);
          end else begin
            e_s = 0; e_b = 0; e_m = 0;
          end
        end
        m_sel = int'(bus.baud_select);
      end
    end
  end

  // per-cycle comparison against the model
  initial begin
    int act;
    int exp;
    forever begin
      @(negedge clk);
      act = {bus.sample_ENABLE, bus.bit_ENABLE,
             bus.mid_ENABLE, bus.sub_cnt};
      exp = {e_s, e_b, e_m, 4'(e_sub)};
      n_assert++;
      if (act != exp) begin
        n_fail++;
        $display("FAIL model t=%0t: got s/b/m/sub=%b, expected %b",
                 $time, 7'(act), 7'(exp));
      end
    end
  end

  task automatic wait_sample(input int lim, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.sample_ENABLE && c < lim);
    if (!bus.sample_ENABLE) c = -1;
  endtask

  task automatic wait_sub(input int val, input int lim);
    int k;
    k = 0;
    while (int'(bus.sub_cnt) != val && k < lim) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run(input int len, output int ns, output int nb,
                     output int gmin, output int gmax);
    int last;
    ns = 0; nb = 0; gmin = 1 << 30; gmax = 0; last = -1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (bus.sample_ENABLE) begin
        if (last >= 0) begin
          if (i - last < gmin) gmin = i - last;
          if (i - last > gmax) gmax = i - last;
        end
        last = i;
        ns++;
      end
      if (bus.bit_ENABLE) nb++;
    end
  endtask

  initial begin
    int c, ns, nb, gmin, gmax, nz;
    bus.enable      = 1'b0;
    bus.baud_select = '0;
    bus.resync      = 1'b0;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.baud_select = 3'd7;
    @(negedge clk);
    bus.enable = 1'b1;
    wait_sample(100, c);
    check("first_strobe_sel7", c, 28);

    // async reset while strobes are active
    wait_sub(3, 300);
    check("pre_reset_subcnt", bus.sub_cnt, 3);
    #3 reset = 1'b0;
    #1;
    check("reset_outputs",
          {bus.sample_ENABLE, bus.bit_ENABLE,
           bus.mid_ENABLE, bus.sub_cnt}, 0);
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.enable = 1'b1;
    wait_sample(100, c);
    check("first_strobe_after_reset", c, 28);

    // long run at 115200
    run(20000, ns, nb, gmin, gmax);
    check_range("sel7_samples", ns, 737, 738);
    check_range("sel7_bits", nb, 46, 47);
    check_range("sel7_gap_min", gmin, 27, 28);
    check_range("sel7_gap_max", gmax, 27, 28);

    // select change 7 -> 3 mid-bit
    wait_sub(5, 600);
    bus.baud_select = 3'd3;
    @(negedge clk);
    check("chg_clear",
          {bus.sample_ENABLE, bus.sub_cnt}, 0);
    wait_sample(1000, c);
    check("chg_first_gap", c, 326);

    // 300 baud
    bus.baud_select = 3'd0;
    run(32000, ns, nb, gmin, gmax);
    check("sel0_samples", ns, 3);
    check_range("sel0_gap_min", gmin, 10414, 10415);
    check_range("sel0_gap_max", gmax, 10414, 10415);

    // resync landing on the 3rd overflow (edge 82 after enable)
    bus.enable      = 1'b0;
    bus.baud_select = 3'd7;
    repeat (2) @(negedge clk);
    bus.enable = 1'b1;
    repeat (81) @(negedge clk);
    check("pre_resync_subcnt", bus.sub_cnt, 2);
    bus.resync = 1'b1;
    @(negedge clk);
    bus.resync = 1'b0;
    check("resync_no_strobe",
          {bus.sample_ENABLE, bus.sub_cnt}, 0);
    ns = 0; c = 0;
    do begin
      @(negedge clk);
      c++;
      if (bus.sample_ENABLE) ns++;
    end while (!bus.mid_ENABLE && c < 1000);
    check("resync_mid_count", ns, 8);
    check("resync_mid_subcnt", bus.sub_cnt, 8);
    do begin
      @(negedge clk);
      c++;
      if (bus.sample_ENABLE) ns++;
    end while (!bus.bit_ENABLE && c < 1000);
    check("resync_bit_count", ns, 16);
    check("resync_bit_subcnt", bus.sub_cnt, 0);

    // disabled for 500 cycles
    bus.enable = 1'b0;
    ns = 0; nz = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.sample_ENABLE || bus.bit_ENABLE ||
          bus.mid_ENABLE) ns++;
      if (bus.sub_cnt != 0) nz++;
    end
    check("disabled_strobes", ns, 0);
    check("disabled_subcnt", nz, 0);
    bus.enable = 1'b1;
    wait_sample(100, c);
    check("reenable_first_strobe", c, 28);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
